// File: rtl/control_sequencer.sv
// Moore control unit for the 32-bit bus datapath: fetch (T0-T2) and execute (T3-T6)
// strobe generation for register-register ALU instructions, with memory wait/timeout.
module control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [4:0]  ALU_NOP     = 5'd0,
    parameter logic [4:0]  ALU_INC     = 5'd7
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] IR_q,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  ALU_Sel,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned NREG   = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT,
        S_FAULT
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                illegal_nxt;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [4:0] alu_op;
    logic       op_legal;
    logic       op_muldiv;
    logic       unused_ir_bits;

    assign op = IR_q[31:27];
    assign ra = IR_q[26:23];
    assign rb = IR_q[22:19];
    assign rc = IR_q[18:15];
    assign unused_ir_bits = ^IR_q[14:0];

    // Opcode decode: ALU select, legality and two-word-result class
    always_comb begin
        alu_op    = ALU_NOP;
        op_legal  = 1'b1;
        op_muldiv = 1'b0;
        case (op)
            OP_ADD:  alu_op = 5'd1;
            OP_SUB:  alu_op = 5'd2;
            OP_AND:  alu_op = 5'd3;
            OP_OR:   alu_op = 5'd4;
            OP_MUL:  begin alu_op = 5'd5; op_muldiv = 1'b1; end
            OP_DIV:  begin alu_op = 5'd6; op_muldiv = 1'b1; end
            OP_HALT: alu_op = ALU_NOP;
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clr) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            instr_count <= cnt_nxt;
            illegal_op  <= illegal_nxt;
        end
    end

    // Next state, bookkeeping and state-decoded strobes
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        cnt_nxt     = instr_count;
        illegal_nxt = illegal_op;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rout     = '0;
        Rin      = '0;
        ALU_Sel  = ALU_NOP;
        busy     = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_T0;
            end
            S_T0: begin
                busy      = 1'b1;
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                ALU_Sel   = ALU_INC;
                state_nxt = S_T1;
            end
            S_T1: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // PC reload only on the first T1 cycle; the wait counter is zero there
                PCin    = (wait_cnt == '0);
                if (mem_ready) begin
                    state_nxt = S_T2;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) state_nxt = S_FAULT;
                end
            end
            S_T2: begin
                busy      = 1'b1;
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                busy = 1'b1;
                if (op == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    Rout = NREG'(1) << rb;
                    Yin  = 1'b1;
                    if (op_legal) begin
                        state_nxt = S_T4;
                    end else begin
                        state_nxt   = S_FAULT;
                        illegal_nxt = 1'b1;
                    end
                end
            end
            S_T4: begin
                busy      = 1'b1;
                Rout      = NREG'(1) << rc;
                Zin       = 1'b1;
                ALU_Sel   = alu_op;
                state_nxt = S_T5;
            end
            S_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (op_muldiv) begin
                    LOin      = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    Rin       = NREG'(1) << ra;
                    cnt_nxt   = instr_count + CNT_W'(1);
                    state_nxt = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                busy      = 1'b1;
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                cnt_nxt   = instr_count + CNT_W'(1);
                state_nxt = run ? S_T0 : S_IDLE;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_T0) wait_nxt = '0;
    end

endmodule
